// File: rtl/conv_result_drain_1d_if.sv
// Handshake bundle for conv_result_drain_1d: frame-in side (in_*) and beat-out side (out_*).
// The master modport is the environment (frame producer / beat consumer), the slave
// modport is the drain itself.
interface conv_result_drain_1d_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int FILTER_L   = 3,
   parameter int RESULT_D   = 8,
   parameter int STRIDE_W   = 1
);
   localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1;
   localparam int RES_WIDTH = 4 * DATA_WIDTH;
   localparam int POS_W     = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;

   logic                                     in_valid;
   logic                                     in_ready;
   logic [RES_WIDTH*RESULT_D*RESULT_W-1:0]   results_in;
   logic [7:0]                               opaque_in;
   logic                                     out_valid;
   logic                                     out_ready;
   logic [RES_WIDTH*RESULT_D-1:0]            out_data;
   logic [POS_W-1:0]                         out_pos;
   logic                                     out_last;
   logic [7:0]                               out_tag;

   modport master (
      output in_valid, results_in, opaque_in, out_ready,
      input  in_ready, out_valid, out_data, out_pos, out_last, out_tag
   );

   modport slave (
      input  in_valid, results_in, opaque_in, out_ready,
      output in_ready, out_valid, out_data, out_pos, out_last, out_tag
   );
endinterface

// File: rtl/conv_result_drain_1d.sv
// conv_result_drain_1d: captures one flat RESULT_D x RESULT_W result frame plus its tag and
// streams it out as RESULT_W beats, one output position (all channels) per beat.
// A new frame may be accepted in the same cycle the last beat transfers, giving
// gap-free back-to-back frames.
// Optional build macro CONV_DRAIN_RELU_EN: clamp each output lane to max(0, signed value).
module conv_result_drain_1d #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 32,
   parameter int FILTER_L   = 3,
   parameter int RESULT_D   = 8,
   parameter int STRIDE_W   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   conv_result_drain_1d_if.slave  bus
);
   localparam int RESULT_W   = (IMG_W - FILTER_L) / STRIDE_W + 1;
   localparam int RES_WIDTH  = 4 * DATA_WIDTH;
   localparam int POS_W      = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
   localparam int FRAME_BITS = RES_WIDTH * RESULT_D * RESULT_W;

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t                        state;
   state_t                        state_next;
   logic [POS_W-1:0]              pos;
   logic [POS_W-1:0]              pos_next;
   logic [FRAME_BITS-1:0]         buffer;
   logic [7:0]                    tag;
   logic                          out_valid;
   logic                          last_pos;
   logic                          beat_done;
   logic                          in_ready;
   logic                          accept;
   logic [RES_WIDTH-1:0]          lane;
   logic [RES_WIDTH*RESULT_D-1:0] data_mux;

   assign out_valid = (state == DRAIN);
   assign last_pos  = (pos == POS_W'(RESULT_W - 1));
   assign beat_done = out_valid && bus.out_ready;
   assign in_ready  = (state == IDLE) || (beat_done && last_pos);
   assign accept    = bus.in_valid && in_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = data_mux;
   assign bus.out_pos   = pos;
   assign bus.out_last  = out_valid && last_pos;
   assign bus.out_tag   = tag;

   // Next-state logic: advance position on each beat transfer, leave DRAIN after the last
   // beat, and restart at position 0 whenever a frame is accepted (including back-to-back).
   always_comb begin
      state_next = state;
      pos_next   = pos;
      if (beat_done) begin
         if (last_pos) begin
            pos_next   = '0;
            state_next = IDLE;
         end else begin
            pos_next = pos + POS_W'(1);
         end
      end
      if (accept) begin
         pos_next   = '0;
         state_next = DRAIN;
      end
   end

   // Beat mux: gather element (d, pos) of every channel into one beat, optionally clamped.
   always_comb begin
      data_mux = '0;
      lane     = '0;
      for (int d = 0; d < RESULT_D; d++) begin
         lane = buffer[(d * RESULT_W + int'(pos)) * RES_WIDTH +: RES_WIDTH];
`ifdef CONV_DRAIN_RELU_EN
         if (lane[RES_WIDTH-1]) begin
            lane = '0;
         end
`endif
         data_mux[d*RES_WIDTH +: RES_WIDTH] = lane;
      end
   end

   // State, position, frame buffer and tag registers; the buffer only loads on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         pos    <= '0;
         buffer <= '0;
         tag    <= '0;
      end else begin
         state <= state_next;
         pos   <= pos_next;
         if (accept) begin
            buffer <= bus.results_in;
            tag    <= bus.opaque_in;
         end
      end
   end
endmodule

// File: tb/tb_conv_result_drain_1d.sv
// Testbench for conv_result_drain_1d. A queue of expected beats is built from each accepted
// frame using the element layout (d,w) -> [(d*RESULT_W+w)*RES_WIDTH +: RES_WIDTH]; every
// cycle the DUT outputs are compared with the head of that queue.
module tb_conv_result_drain_1d;
   localparam int RESULT_W = 30;
   localparam int RESULT_D = 8;
   localparam int RW       = 32;
   localparam int POS_W    = 5;
   localparam int DW       = RW * RESULT_D;
   localparam int FB       = DW * RESULT_W;
   localparam int VW       = 1 + DW + POS_W + 1 + 8 + 1;

   typedef struct {
      logic [DW-1:0]    data;
      logic [POS_W-1:0] pos;
      logic             last;
      logic [7:0]       tag;
   } beat_t;

   logic  clk;
   logic  reset;
   beat_t exp_q[$];
   int    n_compared;
   int    n_failed;
   int    accepts;

   conv_result_drain_1d_if bus ();

   conv_result_drain_1d dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] relu(input logic [RW-1:0] v);
`ifdef CONV_DRAIN_RELU_EN
      if ($signed(v) < 0) return '0;
`endif
      return v;
   endfunction

   // kind 0: (d<<8)|w, kind 1: (d<<8)|w|0x10000, otherwise random words
   function automatic logic [FB-1:0] make_frame(input int kind);
      logic [FB-1:0] f;
      for (int d = 0; d < RESULT_D; d++)
         for (int w = 0; w < RESULT_W; w++)
            if (kind == 0)      f[(d*RESULT_W+w)*RW +: RW] = RW'((d << 8) | w);
            else if (kind == 1) f[(d*RESULT_W+w)*RW +: RW] = RW'((d << 8) | w | 32'h10000);
            else                f[(d*RESULT_W+w)*RW +: RW] = $urandom;
      return f;
   endfunction

   task automatic push_frame(input logic [FB-1:0] f, input logic [7:0] t);
      beat_t b;
      for (int w = 0; w < RESULT_W; w++) begin
         for (int d = 0; d < RESULT_D; d++)
            b.data[d*RW +: RW] = relu(f[(d*RESULT_W+w)*RW +: RW]);
         b.pos  = POS_W'(w);
         b.last = (w == RESULT_W - 1);
         b.tag  = t;
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [VW-1:0] observed_vec();
      return {bus.out_valid, bus.out_data, bus.out_pos, bus.out_last, bus.out_tag, bus.in_ready};
   endfunction

   function automatic logic [VW-1:0] expected_vec();
      if (exp_q.size() == 0)
         return {1'b0, {DW{1'b0}}, {POS_W{1'b0}}, 1'b0, 8'h00, 1'b1};
      return {1'b1, exp_q[0].data, exp_q[0].pos, exp_q[0].last, exp_q[0].tag,
              bus.out_ready & exp_q[0].last};
   endfunction

   // While idle only valid, last and in_ready are defined.
   function automatic logic [VW-1:0] mask_vec();
      if (exp_q.size() == 0)
         return {1'b1, {DW{1'b0}}, {POS_W{1'b0}}, 1'b1, 8'h00, 1'b1};
      return {VW{1'b1}};
   endfunction

   // Advance one clock, updating the expected-beat queue from the inputs seen at the edge.
   task automatic clock_cycle();
      logic ready_exp;
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
      end else begin
         ready_exp = (exp_q.size() == 0) || (bus.out_ready && exp_q[0].last);
         if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
         if (bus.in_valid && ready_exp) begin
            push_frame(bus.results_in, bus.opaque_in);
            accepts++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.results_in = '0;
      bus.opaque_in = 8'h00;
      clock_cycle();
      clock_cycle();
      #1;
      n_compared++;
      if (bus.out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_out_valid observed %b expected 0", bus.out_valid); end
      n_compared++;
      if (bus.in_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL reset_in_ready observed %b expected 1", bus.in_ready); end
      n_compared++;
      if (bus.out_data !== '0) begin n_failed++; $display("[TB] FAIL reset_out_data observed %h expected 0", bus.out_data); end
      n_compared++;
      if (bus.out_tag !== 8'h00) begin n_failed++; $display("[TB] FAIL reset_out_tag observed %h expected 00", bus.out_tag); end
      n_compared++;
      if (bus.out_pos !== '0) begin n_failed++; $display("[TB] FAIL reset_out_pos observed %0d expected 0", bus.out_pos); end
      n_compared++;
      if (bus.out_last !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_out_last observed %b expected 0", bus.out_last); end
      reset = 1'b0;
      clock_cycle();
   endtask

   task automatic test_single_frame();
      int beats = 0;
      bus.results_in = make_frame(0);
      bus.opaque_in = 8'hA5;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 34; c++) begin
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL single_frame c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         if (bus.out_valid === 1'b1) beats++;
         clock_cycle();
         bus.in_valid = 1'b0;
      end
      n_compared++;
      if (beats != RESULT_W) begin n_failed++; $display("[TB] FAIL single_frame_beats observed %0d expected %0d", beats, RESULT_W); end
   endtask

   task automatic test_stall();
      int start = accepts;
      bus.results_in = make_frame(0);
      bus.opaque_in = 8'hA5;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 130; c++) begin
         bus.out_ready = (c % 2 == 1);
         if (accepts == start + 1) begin
            bus.results_in = make_frame(2);
            bus.opaque_in = 8'h77;
         end
         if (accepts >= start + 2) bus.in_valid = 1'b0;
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL stall c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         clock_cycle();
      end
      bus.in_valid = 1'b0;
      n_compared++;
      if (accepts != start + 2) begin n_failed++; $display("[TB] FAIL stall_accepts observed %0d expected %0d", accepts - start, 2); end
   endtask

   task automatic test_back_to_back();
      int  start = accepts;
      logic seen = 1'b0;
      bus.results_in = make_frame(0);
      bus.opaque_in = 8'hA5;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 66; c++) begin
         if (accepts == start + 1) begin
            bus.results_in = make_frame(1);
            bus.opaque_in = 8'h3C;
         end
         if (accepts >= start + 2) bus.in_valid = 1'b0;
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL back_to_back c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         if (accepts == start + 2 && !seen) begin
            seen = 1'b1;
            n_compared++;
            if ({bus.out_valid, bus.out_pos, bus.out_tag} !== {1'b1, POS_W'(0), 8'h3C}) begin
               n_failed++;
               $display("[TB] FAIL back_to_back_first_beat observed %b/%0d/%h expected 1/0/3c", bus.out_valid, bus.out_pos, bus.out_tag);
            end
         end
         clock_cycle();
      end
      n_compared++;
      if (c_check(accepts - start) != 2) begin n_failed++; $display("[TB] FAIL back_to_back_accepts observed %0d expected 2", accepts - start); end
   endtask

   function automatic int c_check(input int v);
      return v;
   endfunction

   task automatic test_reset_mid_drain();
      bus.results_in = make_frame(1);
      bus.opaque_in = 8'h11;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (exp_q.size() != 0 && exp_q[0].pos == POS_W'(10)) break;
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL mid_reset_pre c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         clock_cycle();
         bus.in_valid = 1'b0;
      end
      reset = 1'b1;
      #1;
      n_compared++;
      if (bus.out_pos !== POS_W'(10)) begin n_failed++; $display("[TB] FAIL mid_reset_at_beat observed %0d expected 10", bus.out_pos); end
      clock_cycle();
      reset = 1'b0;
      #1;
      n_compared++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_failed++;
         $display("[TB] FAIL mid_reset_after observed valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
      end
      bus.results_in = make_frame(2);
      bus.opaque_in = 8'h22;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 32; c++) begin
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL mid_reset_next c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         clock_cycle();
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_relu_boundary();
      logic [FB-1:0] f;
      logic [RW-1:0] neg_exp;
      logic          done = 1'b0;
`ifdef CONV_DRAIN_RELU_EN
      neg_exp = 32'h0000_0000;
`else
      neg_exp = 32'hFFFF_FFF6;
`endif
      f = make_frame(0);
      f[(3*RESULT_W+5)*RW +: RW] = 32'hFFFF_FFF6;
      f[(4*RESULT_W+5)*RW +: RW] = 32'h0000_0007;
      f[(6*RESULT_W+9)*RW +: RW] = 32'h8000_0000;
      bus.results_in = f;
      bus.opaque_in = 8'h5E;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 32; c++) begin
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL relu_frame c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         if (!done && exp_q.size() != 0 && exp_q[0].pos == POS_W'(5)) begin
            done = 1'b1;
            n_compared++;
            if (bus.out_data[3*RW +: RW] !== neg_exp) begin
               n_failed++;
               $display("[TB] FAIL relu_negative_lane observed %h expected %h", bus.out_data[3*RW +: RW], neg_exp);
            end
            n_compared++;
            if (bus.out_data[4*RW +: RW] !== 32'h0000_0007) begin
               n_failed++;
               $display("[TB] FAIL relu_positive_lane observed %h expected 00000007", bus.out_data[4*RW +: RW]);
            end
         end
         clock_cycle();
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 340; c++) begin
         if (c < 300) begin
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.opaque_in = 8'($urandom);
            if (bus.in_valid) bus.results_in = make_frame(2);
         end else begin
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
         end
         #1;
         n_compared++;
         if ((observed_vec() & mask_vec()) !== (expected_vec() & mask_vec())) begin
            n_failed++;
            $display("[TB] FAIL random c=%0d observed %h expected %h", c, observed_vec(), expected_vec());
         end
         clock_cycle();
      end
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      n_compared = 0;
      n_failed = 0;
      accepts = 0;
      test_reset();
      test_single_frame();
      test_stall();
      test_back_to_back();
      test_reset_mid_drain();
      test_relu_boundary();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end
endmodule
